// File: rtl/xenyx_pkg.sv
// Shared definitions for the Xenyx-4 control path.
// Holds the controller state enum, the nine legal RV32I opcodes and the
// imm_sel / pc_src / wb_sel encodings used by the controller, the immediate
// generator and the datapath muxes. Also provides decode helpers that map an
// opcode to its immediate format and legality.
package xenyx_pkg;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] PC_PLUS4    = 2'd0;
  localparam logic [1:0] PC_PLUS_IMM = 2'd1;
  localparam logic [1:0] PC_ALU      = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 3'd3;

  function automatic logic opc_legal(input logic [6:0] opc);
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // Unknown opcodes map to IMM_NONE so the generator stays idle.
  function automatic logic [2:0] opc_imm_sel(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_instret_counter.sv
// instret_counter: wrapping up-counter with synchronous active-low clear.
// Ports: clk, clr_n (sync clear, active low), en (count this edge),
//        count (current value, wraps modulo 2^W).
module instret_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WB sequencer for the
// Xenyx-4 RV32I datapath.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   opcode, branch_taken  instruction opcode (valid from DECODE), branch compare
//   imem_req/imem_ack     instruction-fetch handshake
//   dmem_req/dmem_we/dmem_ack  data-memory handshake
//   ir_load, imm_sel, alu_src_a, alu_src_b, pc_write, pc_src,
//   reg_write, wb_sel     datapath controls (combinational)
//   illegal_instr         sticky unknown-opcode flag
//   instret               retired-instruction count
//   dbg_state             current FSM state for observation
//
// Handshakes: a req rises when the FSM enters FETCH (imem) or MEM (dmem) and
// stays high until the cycle its ack is sampled high; the transfer completes
// on that edge. Acks seen while no request is up are ignored, and the two
// requests are never high together.
module multicycle_controller
  import xenyx_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  output logic                 imem_req,
  input  logic                 imem_ack,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic                 ir_load,
  output logic [2:0]           imm_sel,
  output logic                 alu_src_a,
  output logic                 alu_src_b,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 illegal_instr,
  output logic [INSTRET_W-1:0] instret,
  output state_t               dbg_state
);

  state_t     state_q, state_d;
  logic [6:0] opc_q, opc_d;
  logic       illegal_q, illegal_d;
  logic       retire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opc_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_load   = 1'b0;
    imm_sel   = IMM_NONE;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // opc_q is not loaded yet, so decode straight from the IR opcode.
        imm_sel = opc_imm_sel(opcode);
        opc_d   = opcode;
        if (opc_legal(opcode)) begin
          state_d = S_EXECUTE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXECUTE: begin
        imm_sel = opc_imm_sel(opc_q);
        state_d = S_WB;
        case (opc_q)
          OPC_OP_IMM: alu_src_b = 1'b1;
          OPC_LOAD, OPC_STORE: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OPC_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_PLUS_IMM : PC_PLUS4;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          OPC_AUIPC: begin
            alu_src_a = 1'b1;
            alu_src_b = 1'b1;
          end
          // Jumps preselect the target here; the PC is written in WB.
          OPC_JAL:  pc_src = PC_PLUS_IMM;
          OPC_JALR: begin
            alu_src_b = 1'b1;
            pc_src    = PC_ALU;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        imm_sel  = opc_imm_sel(opc_q);
        dmem_req = 1'b1;
        dmem_we  = (opc_q == OPC_STORE);
        if (dmem_ack) begin
          if (opc_q == OPC_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        imm_sel   = opc_imm_sel(opc_q);
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        case (opc_q)
          OPC_LOAD: wb_sel = WB_LOAD;
          OPC_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_PLUS_IMM;
          end
          OPC_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
          OPC_LUI: wb_sel = WB_IMM;
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // While reset is held every control is forced quiet.
    if (!rst_n) begin
      retire    = 1'b0;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_load   = 1'b0;
      imm_sel   = IMM_NONE;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_PLUS4;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
    end
  end

  assign illegal_instr = illegal_q & rst_n;
  assign dbg_state     = state_q;

  instret_counter #(.W(INSTRET_W)) u_instret (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (retire),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import xenyx_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [6:0]   opcode = '0;
  logic         branch_taken = 1'b0;
  logic         imem_ack = 1'b0;
  logic         dmem_ack = 1'b0;
  logic         imem_req, dmem_req, dmem_we, ir_load;
  logic [2:0]   imm_sel;
  logic         alu_src_a, alu_src_b, pc_write, reg_write, illegal_instr;
  logic [1:0]   pc_src, wb_sel;
  logic [W-1:0] instret;
  state_t       dbg_state;

  multicycle_controller #(.INSTRET_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .branch_taken  (branch_taken),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_ack      (dmem_ack),
    .ir_load       (ir_load),
    .imm_sel       (imm_sel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .illegal_instr (illegal_instr),
    .instret       (instret),
    .dbg_state     (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]   lat;    // cycles from first FETCH cycle to PC-update cycle
    logic [3:0]   dcyc;   // cycles with dmem_req high
    logic         we;
    logic [2:0]   imm;
    logic         a;
    logic         b;
    logic [1:0]   pcs;
    logic         rw;
    logic [1:0]   wb;
    logic [W-1:0] ir;     // instret before this retirement
  } exp_t;

  exp_t exp_q[$];
  int   model_cnt = 0;

  function automatic logic is_legal(input logic [6:0] o);
    return o == 7'b0110011 || o == 7'b0010011 || o == 7'b0000011 ||
           o == 7'b0100011 || o == 7'b1100011 || o == 7'b0110111 ||
           o == 7'b0010111 || o == 7'b1101111 || o == 7'b1100111;
  endfunction

  function automatic exp_t build_exp(input logic [6:0] opc, input int iw, input int dw,
                                     input logic bt, input int cnt);
    exp_t e;
    e     = '0;
    e.ir  = cnt[W-1:0];
    e.lat = 8'(iw + 4);
    case (opc)
      7'b0110011: begin e.imm = 3'd7; e.rw = 1'b1; end
      7'b0010011: begin e.imm = 3'd0; e.b = 1'b1; e.rw = 1'b1; end
      7'b0000011: begin
        e.imm = 3'd0; e.b = 1'b1; e.rw = 1'b1; e.wb = 2'd1;
        e.lat = 8'(iw + dw + 5); e.dcyc = 4'(dw + 1);
      end
      7'b0100011: begin
        e.imm = 3'd1; e.b = 1'b1; e.we = 1'b1;
        e.lat = 8'(iw + dw + 4); e.dcyc = 4'(dw + 1);
      end
      7'b1100011: begin e.imm = 3'd2; e.lat = 8'(iw + 3); e.pcs = bt ? 2'd1 : 2'd0; end
      7'b0110111: begin e.imm = 3'd3; e.rw = 1'b1; e.wb = 2'd3; end
      7'b0010111: begin e.imm = 3'd3; e.a = 1'b1; e.b = 1'b1; e.rw = 1'b1; end
      7'b1101111: begin e.imm = 3'd4; e.rw = 1'b1; e.wb = 2'd2; e.pcs = 2'd1; end
      default:    begin e.imm = 3'd0; e.b = 1'b1; e.rw = 1'b1; e.wb = 2'd2; e.pcs = 2'd2; end
    endcase
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0, dcyc = 0, rw_cnt = 0, irl_cnt = 0;
  logic [2:0] cap_imm = 3'd5;
  logic cap_a = 1'bx, cap_b = 1'bx, cap_we = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0; dcyc = 0; rw_cnt = 0; irl_cnt = 0;
      cap_imm = 3'd5; cap_a = 1'bx; cap_b = 1'bx; cap_we = 1'b0;
    end else begin
      cyc++;
      if (imem_req && dmem_req) check("req_overlap", 32'(imem_req & dmem_req), 32'd0);
      if (dbg_state == S_DECODE)  cap_imm = imm_sel;
      if (dbg_state == S_EXECUTE) begin cap_a = alu_src_a; cap_b = alu_src_b; end
      if (dmem_req) begin dcyc++; cap_we = dmem_we; end
      if (reg_write) rw_cnt++;
      if (ir_load) irl_cnt++;
      if (pc_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 32'(pc_write), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("latency", 32'(cyc), 32'(e.lat));
          check("dmem_cycles", 32'(dcyc), 32'(e.dcyc));
          check("dmem_we", 32'(cap_we), 32'(e.we));
          check("imm_sel", 32'(cap_imm), 32'(e.imm));
          check("alu_src_a", 32'(cap_a), 32'(e.a));
          check("alu_src_b", 32'(cap_b), 32'(e.b));
          check("pc_src", 32'(pc_src), 32'(e.pcs));
          check("reg_write_cnt", 32'(rw_cnt), 32'(e.rw));
          if (e.rw) check("wb_sel", 32'(wb_sel), 32'(e.wb));
          check("ir_load_cnt", 32'(irl_cnt), 32'd1);
          check("instret", 32'(instret), 32'(e.ir));
        end
        cyc = 0; dcyc = 0; rw_cnt = 0; irl_cnt = 0;
        cap_imm = 3'd5; cap_a = 1'bx; cap_b = 1'bx; cap_we = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_imem_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      dmem_ack = 1'($urandom_range(0, 1));  // spurious, must be ignored
      @(posedge clk); #1;
      n++;
    end
    dmem_ack = 1'b0;
    check("imem_req_timeout", 32'(imem_req), 32'd1);
  endtask

  task automatic run_instr(input logic [6:0] opc, input int iw, input int dw, input logic bt);
    int n;
    wait_imem_req();
    exp_q.push_back(build_exp(opc, iw, dw, bt, model_cnt));
    model_cnt++;
    for (int i = 0; i < iw; i++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom_range(0, 1));
      opcode   = 7'($urandom);
      @(posedge clk); #1;
    end
    dmem_ack     = 1'b0;
    imem_ack     = 1'b1;
    opcode       = opc;
    branch_taken = (opc == OPC_BRANCH) ? bt : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (opc == OPC_LOAD || opc == OPC_STORE) begin
      n = 0;
      while (!dmem_req && n < 10) begin
        imem_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n++;
      end
      imem_ack = 1'b0;
      check("dmem_req_timeout", 32'(dmem_req), 32'd1);
      for (int i = 0; i < dw; i++) begin @(posedge clk); #1; end
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
  endtask

  task automatic run_random(input int cnt);
    logic [6:0] o;
    for (int k = 0; k < cnt; k++) begin
      case ($urandom_range(0, 8))
        0: o = OPC_OP;    1: o = OPC_OP_IMM; 2: o = OPC_LOAD;
        3: o = OPC_STORE; 4: o = OPC_BRANCH; 5: o = OPC_LUI;
        6: o = OPC_AUIPC; 7: o = OPC_JAL;    default: o = OPC_JALR;
      endcase
      run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobes"}, 32'({imem_req, dmem_req, dmem_we, ir_load, alu_src_a, alu_src_b,
                                 pc_write, reg_write, illegal_instr}), 32'd0);
    check({tag, "_pc_wb"}, 32'({pc_src, wb_sel}), 32'd0);
    check({tag, "_imm"}, 32'(imm_sel), 32'd7);
  endtask

  task automatic run_illegal(input logic [6:0] opc);
    wait_imem_req();
    imem_ack = 1'b1;
    opcode   = opc;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("illegal_in_decode", 32'(illegal_instr), 32'd0);
    @(posedge clk); #1;
    check("illegal_set", 32'(illegal_instr), 32'd1);
    for (int i = 0; i < 20; i++) begin
      imem_ack     = 1'($urandom_range(0, 1));
      dmem_ack     = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      opcode       = 7'($urandom);
      #1;
      check("halt_strobes", 32'({imem_req, dmem_req, dmem_we, ir_load, pc_write, reg_write}), 32'd0);
      check("halt_imm", 32'(imm_sel), 32'd7);
      check("halt_illegal", 32'(illegal_instr), 32'd1);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0; #1;
    check_reset_outputs("halt_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    model_cnt = 0;
    check("post_rst_illegal", 32'(illegal_instr), 32'd0);
    check("post_rst_fetch", 32'(imem_req), 32'd1);
    check("post_rst_instret", 32'(instret), 32'd0);
  endtask

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [6:0] o;
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_instret", 32'(instret), 32'd0);
    rst_n = 1'b1; #1;
    check("reset_release_fetch", 32'(imem_req), 32'd1);

    // Directed pass over every opcode, zero-wait unless noted.
    run_instr(OPC_OP_IMM, 0, 0, 1'b0);
    run_instr(OPC_OP,     0, 0, 1'b0);
    run_instr(OPC_LOAD,   0, 3, 1'b0);
    run_instr(OPC_LOAD,   0, 0, 1'b0);
    run_instr(OPC_STORE,  0, 0, 1'b0);
    run_instr(OPC_STORE,  2, 2, 1'b0);
    run_instr(OPC_BRANCH, 0, 0, 1'b1);
    run_instr(OPC_BRANCH, 0, 0, 1'b0);
    run_instr(OPC_LUI,    0, 0, 1'b0);
    run_instr(OPC_AUIPC,  1, 0, 1'b0);
    run_instr(OPC_JAL,    0, 0, 1'b0);
    run_instr(OPC_JALR,   0, 0, 1'b0);

    run_random(20);               // carries instret past 16 and wraps it
    run_illegal(7'b1111111);
    run_random(10);

    // Reset in the middle of a waiting load.
    wait_imem_req();
    imem_ack = 1'b1;
    opcode   = OPC_LOAD;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    n = 0;
    while (!dmem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("midmem_req", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    check_reset_outputs("midmem_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    model_cnt = 0;
    check("midmem_fetch", 32'(imem_req), 32'd1);
    check("midmem_instret", 32'(instret), 32'd0);

    run_random(18);
    do o = 7'($urandom); while (is_legal(o));
    run_illegal(o);
    run_random(6);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    check("final_instret", 32'(instret), 32'(model_cnt % 16));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
